// File: rtl/cpu_pipeline_ctrl.sv
// Pipeline scheduler: merges stage stall requests into hold/bubble controls and sequences exception/ERET flushes with PC redirect.
// Stall/bubble are combinational in RUN; flush/redirect follow a qualified event by 1 cycle and are extended while IF is busy.
module cpu_pipeline_ctrl #(
    parameter int          CNT_W    = 32,
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_from_if,
    input  logic             stall_from_id,
    input  logic             stall_from_ex,
    input  logic             stall_from_mem,
    input  logic             except_occur,
    input  logic [31:0]      except_vec,
    input  logic             eret,
    input  logic [31:0]      epc,
    output logic [4:0]       stall,
    output logic [4:0]       bubble,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_REDIR_WAIT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_redirect_pc;
    logic [31:0]        w_redirect_pc_nxt;
    logic               w_pc_load;
    logic [CNT_W-1:0]   r_stall_cycles;
    logic [4:0]         w_run_stall;
    logic [4:0]         w_run_bubble;
    logic               w_event;

    // Deepest requesting stage k holds stages 0..k and bubbles the latch feeding k+1.
    always_comb begin
        w_run_stall  = 5'b00000;
        w_run_bubble = 5'b00000;
        if (stall_from_mem) begin
            w_run_stall  = 5'b01111;
            w_run_bubble = 5'b10000;
        end else if (stall_from_ex) begin
            w_run_stall  = 5'b00111;
            w_run_bubble = 5'b01000;
        end else if (stall_from_id) begin
            w_run_stall  = 5'b00011;
            w_run_bubble = 5'b00100;
        end else if (stall_from_if) begin
            w_run_stall  = 5'b00001;
            w_run_bubble = 5'b00010;
        end
    end

    // An event behind a pending data-bus access must wait until MEM completes.
    assign w_event = (except_occur || eret) && !stall_from_mem;

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_load         = 1'b0;
        w_redirect_pc_nxt = r_redirect_pc;
        stall             = 5'b00000;
        bubble            = 5'b00000;
        flush             = 1'b0;
        redirect_valid    = 1'b0;
        case (r_state)
            ST_RUN: begin
                stall  = w_run_stall;
                bubble = w_run_bubble;
                if (w_event) begin
                    w_state_nxt       = ST_FLUSH;
                    w_pc_load         = 1'b1;
                    w_redirect_pc_nxt = except_occur ? except_vec : epc;
                end
            end
            ST_FLUSH: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                w_state_nxt    = stall_from_if ? ST_REDIR_WAIT : ST_RUN;
            end
            ST_REDIR_WAIT: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                stall          = 5'b00001;
                if (!stall_from_if) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_redirect_pc <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            if (w_pc_load) begin
                r_redirect_pc <= w_redirect_pc_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (r_state == ST_RUN && |w_run_stall) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign redirect_pc  = r_redirect_pc;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_cpu_pipeline_ctrl.sv
// Directed bench for cpu_pipeline_ctrl: inputs driven on the falling edge, outputs sampled 1ns later.
module tb_cpu_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_from_if;
    logic        stall_from_id;
    logic        stall_from_ex;
    logic        stall_from_mem;
    logic        except_occur;
    logic [31:0] except_vec;
    logic        eret;
    logic [31:0] epc;
    logic [4:0]  stall;
    logic [4:0]  bubble;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] stall_cycles;

    int n_chk = 0;
    int n_err = 0;

    cpu_pipeline_ctrl #(.CNT_W(32), .RESET_PC(32'hbfc00000)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_from_if  (stall_from_if),
        .stall_from_id  (stall_from_id),
        .stall_from_ex  (stall_from_ex),
        .stall_from_mem (stall_from_mem),
        .except_occur   (except_occur),
        .except_vec     (except_vec),
        .eret           (eret),
        .epc            (epc),
        .stall          (stall),
        .bubble         (bubble),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_cycles   (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Packs {stall, bubble, flush, redirect_valid} into one comparison.
    task automatic chk_ctl(input string tag, input logic [4:0] st, input logic [4:0] bb,
                           input logic fl, input logic rv);
        chk({tag, ".ctl"}, {20'd0, stall, bubble, flush, redirect_valid},
            {20'd0, st, bb, fl, rv});
    endtask

    task automatic next_sample();
        @(negedge clk);
    endtask

    // Raise an event for one cycle with IF idle; expect a single flush cycle, then idle RUN.
    task automatic do_event(input string tag, input logic exc, input logic er,
                            input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
        except_occur = exc;
        eret         = er;
        #1 chk_ctl({tag, ".evt"}, 5'b00000, 5'b00000, 1'b0, 1'b0);
        next_sample();
        except_occur = 1'b0;
        eret         = 1'b0;
        #1 chk_ctl({tag, ".flush"}, 5'b00000, 5'b00000, 1'b1, 1'b1);
        chk({tag, ".pc"}, redirect_pc, exp_pc);
        next_sample();
        #1 chk_ctl({tag, ".after"}, 5'b00000, 5'b00000, 1'b0, 1'b0);
        chk({tag, ".cnt"}, stall_cycles, exp_cnt);
    endtask

    initial begin
        rst            = 1'b1;
        stall_from_if  = 1'b0;
        stall_from_id  = 1'b0;
        stall_from_ex  = 1'b0;
        stall_from_mem = 1'b0;
        except_occur   = 1'b0;
        except_vec     = 32'h0;
        eret           = 1'b0;
        epc            = 32'h0;
        repeat (2) @(posedge clk);
        next_sample();
        rst = 1'b0;
        #1 chk_ctl("reset", 5'b00000, 5'b00000, 1'b0, 1'b0);
        chk("reset.pc", redirect_pc, 32'hbfc00000);
        chk("reset.cnt", stall_cycles, 32'd0);

        // ID load-use stall for three cycles
        next_sample();
        stall_from_id = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk_ctl("id_stall", 5'b00011, 5'b00100, 1'b0, 1'b0);
            next_sample();
        end
        stall_from_id = 1'b0;
        #1 chk_ctl("id_release", 5'b00000, 5'b00000, 1'b0, 1'b0);
        chk("id_stall.cnt", stall_cycles, 32'd3);

        // Deepest requester wins
        next_sample();
        stall_from_id  = 1'b1;
        stall_from_ex  = 1'b1;
        stall_from_mem = 1'b1;
        #1 chk_ctl("mem_deepest", 5'b01111, 5'b10000, 1'b0, 1'b0);
        next_sample();
        stall_from_mem = 1'b0;
        #1 chk_ctl("ex_deepest", 5'b00111, 5'b01000, 1'b0, 1'b0);
        next_sample();
        stall_from_ex = 1'b0;
        stall_from_id = 1'b0;
        stall_from_if = 1'b1;
        #1 chk_ctl("if_only", 5'b00001, 5'b00010, 1'b0, 1'b0);
        next_sample();
        stall_from_if = 1'b0;
        #1 chk("multi.cnt", stall_cycles, 32'd6);

        // Exception, then priority and ERET
        next_sample();
        except_vec = 32'hbfc00380;
        epc        = 32'h80001000;
        do_event("exc", 1'b1, 1'b0, 32'hbfc00380, 32'd6);
        do_event("eret", 1'b0, 1'b1, 32'h80001000, 32'd6);
        do_event("both", 1'b1, 1'b1, 32'hbfc00380, 32'd6);
        do_event("eret2", 1'b0, 1'b1, 32'h80001000, 32'd6);

        // Exception while IF busy; squashed requests during redirect are ignored
        except_vec   = 32'hbfc00380;
        except_occur = 1'b1;
        #1 chk_ctl("ifb.evt", 5'b00000, 5'b00000, 1'b0, 1'b0);
        next_sample();
        except_occur  = 1'b0;
        stall_from_if = 1'b1;
        #1 chk_ctl("ifb.flush", 5'b00000, 5'b00000, 1'b1, 1'b1);
        next_sample();
        stall_from_id  = 1'b1;
        stall_from_mem = 1'b1;
        except_occur   = 1'b1;
        except_vec     = 32'hbfc00999;
        eret           = 1'b1;
        #1 chk_ctl("ifb.wait1", 5'b00001, 5'b00000, 1'b1, 1'b1);
        next_sample();
        #1 chk_ctl("ifb.wait2", 5'b00001, 5'b00000, 1'b1, 1'b1);
        chk("ifb.pc_hold", redirect_pc, 32'hbfc00380);
        next_sample();
        stall_from_if  = 1'b0;
        stall_from_id  = 1'b0;
        stall_from_mem = 1'b0;
        except_occur   = 1'b0;
        eret           = 1'b0;
        #1 chk_ctl("ifb.wait3", 5'b00001, 5'b00000, 1'b1, 1'b1);
        next_sample();
        #1 chk_ctl("ifb.run", 5'b00000, 5'b00000, 1'b0, 1'b0);
        chk("ifb.cnt", stall_cycles, 32'd6);
        chk("ifb.pc", redirect_pc, 32'hbfc00380);

        // Event blocked by MEM stall, then reset from REDIR_WAIT
        next_sample();
        except_vec     = 32'hbfc00500;
        except_occur   = 1'b1;
        stall_from_mem = 1'b1;
        #1 chk_ctl("memblk.0", 5'b01111, 5'b10000, 1'b0, 1'b0);
        next_sample();
        #1 chk_ctl("memblk.1", 5'b01111, 5'b10000, 1'b0, 1'b0);
        next_sample();
        stall_from_mem = 1'b0;
        #1 chk_ctl("memblk.rel", 5'b00000, 5'b00000, 1'b0, 1'b0);
        chk("memblk.pc_old", redirect_pc, 32'hbfc00380);
        next_sample();
        except_occur  = 1'b0;
        stall_from_if = 1'b1;
        #1 chk_ctl("memblk.flush", 5'b00000, 5'b00000, 1'b1, 1'b1);
        chk("memblk.pc", redirect_pc, 32'hbfc00500);
        chk("memblk.cnt", stall_cycles, 32'd8);
        next_sample();
        rst = 1'b1;
        #1 chk_ctl("rstwait.wait", 5'b00001, 5'b00000, 1'b1, 1'b1);
        next_sample();
        rst           = 1'b0;
        stall_from_if = 1'b0;
        #1 chk_ctl("rstwait.ctl", 5'b00000, 5'b00000, 1'b0, 1'b0);
        chk("rstwait.pc", redirect_pc, 32'hbfc00000);
        chk("rstwait.cnt", stall_cycles, 32'd0);

        // Counter wrap
        next_sample();
        force dut.r_stall_cycles = 32'hffffffff;
        #1 release dut.r_stall_cycles;
        chk("wrap.pre", stall_cycles, 32'hffffffff);
        stall_from_ex = 1'b1;
        next_sample();
        stall_from_ex = 1'b0;
        #1 chk("wrap.cnt", stall_cycles, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
